// File: rtl/ropuf_pkg.sv
// Shared definitions for the ring-oscillator PUF sequencer: FSM encoding,
// mux geometry and the pair-select helper.
package ropuf_pkg;

  localparam int N_RO        = 16;
  localparam int SEL_W       = 4;
  localparam int PAIR_OFFSET = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_COUNT   = 3'd2;
  localparam logic [2:0] ST_COMPARE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    SETTLE  = ST_SETTLE,
    COUNT   = ST_COUNT,
    COMPARE = ST_COMPARE,
    DONE    = ST_DONE
  } state_t;

  // Oscillator index for pair idx; the sum wraps modulo N_RO by truncation.
  function automatic logic [SEL_W-1:0] pair_sel(input logic [SEL_W-1:0] base,
                                                input int unsigned idx,
                                                input int unsigned off);
    return base + SEL_W'(idx) + SEL_W'(off);
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Counts synchronized rising edges of one asynchronous oscillator output,
// saturating at all-ones.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             ro,
  output logic [CNT_W-1:0] cnt
);

  // sync[0..1] form the two-flop synchronizer, sync[2] remembers the last synced level
  logic [2:0] sync;
  logic       rise;

  // Synchronizer and edge-history shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 3'b000;
    end else begin
      sync <= {sync[1:0], ro};
    end
  end

  assign rise = sync[1] & ~sync[2];

  // Saturating edge counter, cleared while the pair is settling.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && rise && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/ropuf_ctrl.sv
// Ring-oscillator PUF sequencer: steps through RESP_BITS oscillator pairs,
// races each pair over a fixed window and packs the comparison bits.
module ropuf_ctrl
  import ropuf_pkg::*;
#(
  parameter int RESP_BITS = 8,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 1024,
  parameter int SETTLE_CYC = 8,
  localparam int TIE_W    = $clog2(RESP_BITS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SEL_W-1:0]     seed,
  input  logic                 ro_a,
  input  logic                 ro_b,
  output logic [SEL_W-1:0]     sel_a,
  output logic [SEL_W-1:0]     sel_b,
  output logic                 ro_en,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic [TIE_W-1:0]     tie_cnt
);

  localparam int KW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int MAXC = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TW   = $clog2(MAXC + 1);

  state_t           state;
  logic [SEL_W-1:0] seed_q;
  logic [KW-1:0]    k;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             cnt_clr;
  logic             cnt_en;

  assign cnt_clr = (state == SETTLE);
  assign cnt_en  = (state == COUNT);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(cnt_en), .ro(ro_a), .cnt(cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(cnt_en), .ro(ro_b), .cnt(cnt_b)
  );

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      seed_q   <= '0;
      k        <= '0;
      timer    <= '0;
      sel_a    <= '0;
      sel_b    <= '0;
      ro_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= '0;
      tie_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            seed_q   <= seed;
            k        <= '0;
            timer    <= '0;
            sel_a    <= pair_sel(seed, 0, 0);
            sel_b    <= pair_sel(seed, 0, PAIR_OFFSET);
            ro_en    <= 1'b1;
            busy     <= 1'b1;
            response <= '0;
            tie_cnt  <= '0;
            state    <= SETTLE;
          end else begin
            state <= IDLE;
          end
        end
        SETTLE: begin
          if (timer == TW'(SETTLE_CYC - 1)) begin
            timer <= '0;
            state <= COUNT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        COUNT: begin
          if (timer == TW'(WINDOW - 1)) begin
            timer <= '0;
            state <= COMPARE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        COMPARE: begin
          response[k] <= (cnt_a > cnt_b);
          if (cnt_a == cnt_b) begin
            tie_cnt <= tie_cnt + TIE_W'(1);
          end else begin
            tie_cnt <= tie_cnt;
          end
          if (k == KW'(RESP_BITS - 1)) begin
            ro_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // Selects only move here, so the muxes see one clean change per pair.
            k     <= k + KW'(1);
            sel_a <= pair_sel(seed_q, 32'(k) + 32'd1, 0);
            sel_b <= pair_sel(seed_q, 32'(k) + 32'd1, PAIR_OFFSET);
            state <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ropuf_ctrl.sv
// Self-checking bench for ropuf_ctrl with a behavioural oscillator-array model.
`timescale 1ns/1ps
module tb_ropuf_ctrl;

  localparam int RB  = 8;
  localparam int S1  = 4;
  localparam int W1  = 100;
  localparam int W2  = 200;
  localparam int LAT1 = RB * (S1 + W1 + 1) + 1;
  localparam int LAT2 = RB * (S1 + W2 + 1) + 1;

  logic       clk = 1'b0;
  logic       rst, start, start2, tie_mode;
  logic [3:0] seed;
  logic       ro_a = 1'b0;
  logic       ro_b_gen = 1'b0;
  logic       ro_b;

  logic [3:0] sel_a1, sel_b1, sel_a2, sel_b2;
  logic       ro_en1, busy1, done1, ro_en2, busy2, done2;
  logic [7:0] resp1, resp2;
  logic [3:0] tie1, tie2;

  int per[16] = '{default: 40};
  bit fast[16];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [3:0] qa[$];
  logic [3:0] qb[$];

  typedef struct {
    logic [3:0] seed;
    int         tbl;
    bit         tie;
    logic [7:0] exp_resp;
    logic [3:0] exp_tie;
  } vec_t;
  vec_t vecs[4];

  ropuf_ctrl #(.RESP_BITS(RB), .CNT_W(16), .WINDOW(W1), .SETTLE_CYC(S1)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .ro_a(ro_a), .ro_b(ro_b),
    .sel_a(sel_a1), .sel_b(sel_b1), .ro_en(ro_en1), .busy(busy1), .done(done1),
    .response(resp1), .tie_cnt(tie1)
  );

  ropuf_ctrl #(.RESP_BITS(RB), .CNT_W(4), .WINDOW(W2), .SETTLE_CYC(S1)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .seed(seed), .ro_a(ro_a), .ro_b(ro_b),
    .sel_a(sel_a2), .sel_b(sel_b2), .ro_en(ro_en2), .busy(busy2), .done(done2),
    .response(resp2), .tie_cnt(tie2)
  );

  always #5 clk = ~clk;

  // Oscillator array: each mux output runs at the period of the selected ring.
  always begin
    #((per[sel_a1] < 20 ? 20 : per[sel_a1]) / 2);
    ro_a = ~ro_a;
  end
  always begin
    #((per[sel_b1] < 20 ? 20 : per[sel_b1]) / 2);
    ro_b_gen = ~ro_b_gen;
  end
  assign ro_b = tie_mode ? ro_a : ro_b_gen;

  always @(negedge clk) begin
    if (done1) done_cnt++;
    if (busy1 && (qa.size() == 0 || qa[$] != sel_a1 || qb[$] != sel_b1)) begin
      qa.push_back(sel_a1);
      qb.push_back(sel_b1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_tbl(input int tbl);
    for (int i = 0; i < 16; i++) begin
      if (tbl == 1) per[i] = (i < 8) ? 40 : 60;
      else          per[i] = (i < 8) ? 40 : (((i - 8) % 2 == 0) ? 30 : 50);
    end
  endtask

  function automatic bit seq_ok(input logic [3:0] sd);
    if (qa.size() != RB) return 1'b0;
    for (int k = 0; k < RB; k++) begin
      if (int'(qa[k]) != (int'(sd) + k) % 16) return 1'b0;
      if (int'(qb[k]) != (int'(sd) + k + 8) % 16) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Pulses start (and optionally start2) and counts cycles until done1.
  task automatic run1(input logic [3:0] sd, input bit both, output int lat);
    @(posedge clk); #1;
    qa.delete(); qb.delete();
    seed = sd; start = 1'b1; start2 = both;
    lat = 0;
    @(posedge clk); lat = 1; #1;
    start = 1'b0; start2 = 1'b0;
    while (!done1 && lat < LAT1 + 50) begin
      @(posedge clk); lat++; #1;
    end
  endtask

  initial begin
    int lat, g;
    logic [7:0] exp_r, mask;
    logic [3:0] sd;

    vecs[0] = '{seed: 4'h0, tbl: 1, tie: 1'b0, exp_resp: 8'hFF, exp_tie: 4'd0};
    vecs[1] = '{seed: 4'hC, tbl: 1, tie: 1'b0, exp_resp: 8'hF0, exp_tie: 4'd0};
    vecs[2] = '{seed: 4'h0, tbl: 2, tie: 1'b0, exp_resp: 8'hAA, exp_tie: 4'd0};
    vecs[3] = '{seed: 4'h5, tbl: 1, tie: 1'b1, exp_resp: 8'h00, exp_tie: 4'd8};

    rst = 1'b1; start = 1'b0; start2 = 1'b0; seed = 4'h0; tie_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {8'h0, sel_a1, sel_b1, ro_en1, busy1, done1, resp1, tie1, 1'b0}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      set_tbl(vecs[i].tbl);
      tie_mode = vecs[i].tie;
      run1(vecs[i].seed, (i == 0), lat);
      chk("latency", lat, LAT1);
      chk("response", resp1, vecs[i].exp_resp);
      chk("tie_cnt", tie1, vecs[i].exp_tie);
      chk("done_flags", {busy1, ro_en1, done1}, 3'b001);
      chk("sel_seq", seq_ok(vecs[i].seed), 1);
      @(posedge clk); #1;
      chk("done_single", done1, 1'b0);
      if (i == 0) begin
        lat++;
        while (!done2 && lat < LAT2 + 50) begin
          @(posedge clk); lat++; #1;
        end
        chk("sat_latency", lat, LAT2);
        chk("sat_response", resp2, 8'h00);
        chk("sat_tie_cnt", tie2, 4'd8);
      end
    end
    tie_mode = 1'b0;

    // Random ring frequencies in two well-separated classes; only decisive pairs checked.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        fast[i] = $urandom_range(1, 0) == 1;
        per[i] = fast[i] ? 2 * $urandom_range(15, 12) : 2 * $urandom_range(35, 25);
      end
      sd = 4'($urandom_range(15, 0));
      exp_r = 8'h00; mask = 8'h00;
      for (int k = 0; k < RB; k++) begin
        if (fast[(sd + k) % 16] != fast[(sd + k + 8) % 16]) begin
          mask[k] = 1'b1;
          exp_r[k] = fast[(sd + k) % 16];
        end
      end
      run1(sd, 1'b0, lat);
      chk("rand_latency", lat, LAT1);
      chk("rand_response", resp1 & mask, exp_r);
      chk("rand_sel_seq", seq_ok(sd), 1);
    end

    // Reset in the middle of pair 3's counting window.
    set_tbl(1);
    @(posedge clk); #1;
    seed = 4'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    g = 0;
    while (sel_a1 != 4'd3 && g < 2000) begin
      @(posedge clk); #1; g++;
    end
    chk("reach_pair3", g < 2000, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("pre_reset_resp", resp1, 8'h07);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_state", {sel_a1, busy1, ro_en1, done1, resp1}, 16'h0);
    done_cnt = 0;
    repeat (LAT1 + 20) @(posedge clk);
    chk("abort_no_done", done_cnt, 0);

    // Second start while busy is ignored; start during DONE is ignored too.
    done_cnt = 0;
    @(posedge clk); #1;
    qa.delete(); qb.delete();
    seed = 4'h2; start = 1'b1; lat = 0;
    @(posedge clk); lat = 1; #1;
    start = 1'b0;
    while (!done1 && lat < LAT1 + 50) begin
      if (lat == 50) begin seed = 4'h9; start = 1'b1; end
      else begin start = 1'b0; end
      @(posedge clk); lat++; #1;
    end
    chk("busy_latency", lat, LAT1);
    chk("busy_sel_seq", seq_ok(4'h2), 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("start_in_done", {busy1, ro_en1}, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    chk("one_done", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
